// File: rtl/nco_pkg.sv
// Shared NCO definitions: tuning-word width, sweep mode and sweep FSM state types.
package nco_pkg;

    localparam int unsigned NCO_FW_W = 32;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_RSVD   = 2'b11
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DWELL = 2'b01,
        STEP  = 2'b10
    } sweep_state_t;

    function automatic logic mode_valid(input logic [1:0] i_mode);
        return i_mode != MODE_RSVD;
    endfunction

endpackage

// File: rtl/nco_sweep_step.sv
// Combinational next-word arithmetic for the sweep: 33-bit add/sub clamped to the
// sweep limits, plus flags telling whether the current word already sits on a limit.
module nco_sweep_step
    import nco_pkg::*;
#(
    parameter int unsigned FW_W = NCO_FW_W
) (
    input  logic [FW_W-1:0] i_cur,
    input  logic [FW_W-1:0] i_step,
    input  logic [FW_W-1:0] i_lo,
    input  logic [FW_W-1:0] i_hi,
    output logic [FW_W-1:0] o_up,
    output logic [FW_W-1:0] o_dn,
    output logic            o_at_hi,
    output logic            o_at_lo
);

    logic [FW_W:0] w_sum;
    logic [FW_W:0] w_floor;

    always_comb begin
        w_sum   = {1'b0, i_cur} + {1'b0, i_step};
        // cur - step <= lo  <=>  cur <= lo + step, evaluated without underflow
        w_floor = {1'b0, i_lo} + {1'b0, i_step};
        o_up    = (w_sum >= {1'b0, i_hi}) ? i_hi : w_sum[FW_W-1:0];
        o_dn    = ({1'b0, i_cur} <= w_floor) ? i_lo : (i_cur - i_step);
        o_at_hi = (i_cur >= i_hi);
        o_at_lo = (i_cur <= i_lo);
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-word sequencer feeding the NCO tuning input: single-up, sawtooth and
// triangle chirps between latched start/stop words with programmable step and dwell.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned FW_W    = NCO_FW_W,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FW_W-1:0]    cfg_f_start,
    input  logic [FW_W-1:0]    cfg_f_stop,
    input  logic [FW_W-1:0]    cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [FW_W-1:0]    freq_word,
    output logic               busy,
    output logic               dir_down,
    output logic               sweep_done,
    output logic               cfg_err
);

    sweep_state_t        r_state;
    logic [FW_W-1:0]     r_freq;
    logic                r_busy;
    logic                r_dir;
    logic                r_done;
    logic                r_err;
    logic [DWELL_W-1:0]  r_cnt;

    logic [FW_W-1:0]     r_f_start;
    logic [FW_W-1:0]     r_f_stop;
    logic [FW_W-1:0]     r_step;
    logic [DWELL_W-1:0]  r_dwell;
    sweep_mode_t         r_mode;

    sweep_state_t        w_state_nxt;
    logic [FW_W-1:0]     w_freq_nxt;
    logic                w_busy_nxt;
    logic                w_dir_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic [DWELL_W-1:0]  w_cnt_nxt;
    logic                w_latch;
    logic                w_cfg_ok;

    logic [FW_W-1:0]     w_up;
    logic [FW_W-1:0]     w_dn;
    logic                w_at_hi;
    logic                w_at_lo;

    nco_sweep_step #(
        .FW_W(FW_W)
    ) u_step (
        .i_cur   (r_freq),
        .i_step  (r_step),
        .i_lo    (r_f_start),
        .i_hi    (r_f_stop),
        .o_up    (w_up),
        .o_dn    (w_dn),
        .o_at_hi (w_at_hi),
        .o_at_lo (w_at_lo)
    );

    assign w_cfg_ok = (cfg_f_start <= cfg_f_stop) && (cfg_step != '0) && mode_valid(cfg_mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_freq    <= '0;
            r_busy    <= 1'b0;
            r_dir     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_step    <= '0;
            r_dwell   <= '0;
            r_mode    <= MODE_SINGLE;
        end else begin
            r_state <= w_state_nxt;
            r_freq  <= w_freq_nxt;
            r_busy  <= w_busy_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_f_start <= cfg_f_start;
                r_f_stop  <= cfg_f_stop;
                r_step    <= cfg_step;
                r_dwell   <= cfg_dwell;
                r_mode    <= sweep_mode_t'(cfg_mode);
            end
        end
    end

    // The word update happens on the edge that leaves a zero count, so STEP marks the
    // first cycle of a new word and otherwise counts down exactly like DWELL.
    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_busy_nxt  = r_busy;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;

        if (abort) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_dir_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            w_latch     = 1'b1;
                            w_freq_nxt  = cfg_f_start;
                            w_busy_nxt  = 1'b1;
                            w_dir_nxt   = 1'b0;
                            w_cnt_nxt   = cfg_dwell;
                            w_state_nxt = DWELL;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                DWELL, STEP: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt   = r_cnt - DWELL_W'(1);
                        w_state_nxt = DWELL;
                    end else begin
                        w_cnt_nxt   = r_dwell;
                        w_state_nxt = STEP;
                        if (!r_dir) begin
                            if (!w_at_hi) begin
                                w_freq_nxt = w_up;
                            end else begin
                                case (r_mode)
                                    MODE_SAW: w_freq_nxt = r_f_start;
                                    MODE_TRI: begin
                                        w_dir_nxt  = 1'b1;
                                        w_freq_nxt = w_dn;
                                    end
                                    MODE_SINGLE: begin
                                        w_state_nxt = IDLE;
                                        w_busy_nxt  = 1'b0;
                                        w_done_nxt  = 1'b1;
                                    end
                                    default: begin
                                        w_state_nxt = IDLE;
                                        w_busy_nxt  = 1'b0;
                                    end
                                endcase
                            end
                        end else begin
                            if (!w_at_lo) begin
                                w_freq_nxt = w_dn;
                            end else begin
                                w_dir_nxt  = 1'b0;
                                w_freq_nxt = w_up;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_dir_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign freq_word  = r_freq;
    assign busy       = r_busy;
    assign dir_down   = r_dir;
    assign sweep_done = r_done;
    assign cfg_err    = r_err;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: config-check table, hand-written corner
// sequences, and randomized sweeps compared against a word-list reference model.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_f_start = '0;
    logic [31:0] cfg_f_stop = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] freq_word;
    logic        busy;
    logic        dir_down;
    logic        sweep_done;
    logic        cfg_err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [31:0] fs;
        logic [31:0] fe;
        logic [31:0] st;
        logic [1:0]  md;
        logic        err;
    } cfg_vec_t;

    typedef struct {
        logic [31:0] f;
        logic        b;
        logic        d;
        logic        p;
    } exp_t;

    cfg_vec_t tbl[8];
    exp_t     q[$];

    nco_sweep_ctrl #(
        .FW_W    (32),
        .DWELL_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .freq_word   (freq_word),
        .busy        (busy),
        .dir_down    (dir_down),
        .sweep_done  (sweep_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compares {freq_word, busy, dir_down, sweep_done, cfg_err} in one go.
    task automatic chk_out(input string name, input logic [31:0] f, input logic b,
                           input logic d, input logic p, input logic e);
        logic [35:0] act;
        logic [35:0] exp;
        act = {freq_word, busy, dir_down, sweep_done, cfg_err};
        exp = {f, b, d, p, e};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got freq=%0h busy=%b dir=%b done=%b err=%b, expected freq=%0h busy=%b dir=%b done=%b err=%b",
                     name, $time, freq_word, busy, dir_down, sweep_done, cfg_err, f, b, d, p, e);
        end
    endtask

    task automatic do_start(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                            input logic [15:0] dw, input logic [1:0] md);
        cfg_f_start = fs;
        cfg_f_stop  = fe;
        cfg_step    = st;
        cfg_dwell   = dw;
        cfg_mode    = md;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic do_abort;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic scramble_cfg;
        cfg_f_start = $urandom;
        cfg_f_stop  = $urandom;
        cfg_step    = $urandom_range(0, 3);
        cfg_dwell   = 16'($urandom);
        cfg_mode    = 2'($urandom_range(0, 3));
        start       = 1'($urandom_range(0, 1));
    endtask

    // Reference: list of words, each held dwell+1 cycles, following the sweep rules.
    task automatic build_model(input longint fs, input longint fe, input longint st,
                               input int unsigned dw, input int unsigned md);
        longint v;
        bit     desc;
        v    = fs;
        desc = 1'b0;
        q.delete();
        while (q.size() < 60) begin
            for (int unsigned r = 0; r <= dw; r++) q.push_back('{v[31:0], 1'b1, desc, 1'b0});
            if (!desc) begin
                if (v == fe) begin
                    if (md == 0) begin
                        q.push_back('{fe[31:0], 1'b0, 1'b0, 1'b1});
                        q.push_back('{fe[31:0], 1'b0, 1'b0, 1'b0});
                        break;
                    end else if (md == 1) begin
                        v = fs;
                    end else begin
                        desc = 1'b1;
                        v = (fe - st > fs) ? fe - st : fs;
                    end
                end else begin
                    v = (v + st < fe) ? v + st : fe;
                end
            end else begin
                if (v == fs) begin
                    desc = 1'b0;
                    v = (v + st < fe) ? v + st : fe;
                end else begin
                    v = (v - st > fs) ? v - st : fs;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] exp_f;
        logic [31:0] e1[8];
        logic [31:0] e2[6];
        logic [31:0] e3[9];
        logic        d3[9];
        logic [31:0] e4[5];
        longint      base;
        longint      top;
        logic [31:0] fs;
        logic [31:0] fe;
        logic [31:0] st;
        logic [15:0] dw;
        logic [1:0]  md;
        exp_t        last;

        tbl[0] = '{32'd200, 32'd100, 32'd10, 2'b00, 1'b1};
        tbl[1] = '{32'd100, 32'd200, 32'd0,  2'b00, 1'b1};
        tbl[2] = '{32'd100, 32'd200, 32'd10, 2'b11, 1'b1};
        tbl[3] = '{32'd100, 32'd100, 32'd5,  2'b00, 1'b0};
        tbl[4] = '{32'd0,   32'hFFFF_FFFF, 32'd1, 2'b01, 1'b0};
        tbl[5] = '{32'd5,   32'd6,   32'hFFFF_FFFF, 2'b10, 1'b0};
        tbl[6] = '{32'd201, 32'd200, 32'd1,  2'b10, 1'b1};
        tbl[7] = '{32'd77,  32'd77,  32'd1,  2'b10, 1'b0};

        e1 = '{32'd100, 32'd100, 32'd110, 32'd110, 32'd120, 32'd120, 32'd130, 32'd130};
        e2 = '{32'd100, 32'd100, 32'd125, 32'd125, 32'd130, 32'd130};
        e3 = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd120, 32'd110, 32'd100, 32'd110, 32'd120};
        d3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        e4 = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FF80};

        #12;
        chk_out("reset_state", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4 rst = 1'b1;
        tick();
        chk_out("after_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        prev = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            do_start(tbl[i].fs, tbl[i].fe, tbl[i].st, 16'd3, tbl[i].md);
            exp_f = tbl[i].err ? prev : tbl[i].fs;
            chk_out("tbl_start", exp_f, !tbl[i].err, 1'b0, 1'b0, tbl[i].err);
            tick();
            chk_out("tbl_next", exp_f, !tbl[i].err, 1'b0, 1'b0, 1'b0);
            if (!tbl[i].err) begin
                do_abort();
                chk_out("tbl_abort", exp_f, 1'b0, 1'b0, 1'b0, 1'b0);
                prev = tbl[i].fs;
            end
        end

        do_start(32'd100, 32'd130, 32'd10, 16'd1, 2'b00);
        for (int unsigned i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk_out("single_step10", e1[i], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_out("single_done", 32'd130, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("single_hold", 32'd130, 1'b0, 1'b0, 1'b0, 1'b0);

        do_start(32'd100, 32'd130, 32'd25, 16'd1, 2'b00);
        for (int unsigned i = 0; i < 6; i++) begin
            if (i > 0) tick();
            chk_out("single_clamp", e2[i], 1'b1, 1'b0, 1'b0, 1'b0);
            scramble_cfg();
        end
        start = 1'b0;
        tick();
        chk_out("clamp_done", 32'd130, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("clamp_hold", 32'd130, 1'b0, 1'b0, 1'b0, 1'b0);

        do_start(32'd100, 32'd130, 32'd10, 16'd0, 2'b10);
        for (int unsigned i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk_out("triangle", e3[i], 1'b1, d3[i], 1'b0, 1'b0);
        end
        do_abort();
        chk_out("tri_abort", 32'd120, 1'b0, 1'b0, 1'b0, 1'b0);

        do_start(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h80, 16'd0, 2'b01);
        for (int unsigned i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk_out("saw_top", e4[i], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        do_abort();
        chk_out("saw_abort", 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 1'b0);

        do_start(32'd100, 32'd130, 32'd10, 16'd1, 2'b00);
        tick();
        tick();
        chk_out("abort_pre", 32'd110, 1'b1, 1'b0, 1'b0, 1'b0);
        do_abort();
        chk_out("abort_at110", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            chk_out("abort_quiet", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        cfg_f_start = 32'd50;
        cfg_f_stop  = 32'd60;
        cfg_step    = 32'd1;
        cfg_mode    = 2'b00;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_out("start_abort_idle", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("start_abort_idle2", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);

        do_start(32'd100, 32'd130, 32'd10, 16'd1, 2'b00);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk_out("rst_async", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        tick();
        chk_out("rst_released", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rst_no_done", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int unsigned it = 0; it < 30; it++) begin
            base = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FE00 : longint'($urandom_range(0, 1000));
            top  = base + longint'($urandom_range(0, 200));
            if (top > 64'hFFFF_FFFF) top = 64'hFFFF_FFFF;
            fs = base[31:0];
            fe = top[31:0];
            st = ($urandom_range(0, 4) == 0) ? ($urandom | 32'd1) : 32'($urandom_range(1, 80));
            dw = 16'($urandom_range(0, 3));
            md = 2'($urandom_range(0, 2));
            build_model(longint'(fs), longint'(fe), longint'(st), int'(dw), int'(md));
            do_start(fs, fe, st, dw, md);
            for (int unsigned k = 0; k < q.size(); k++) begin
                if (k > 0) tick();
                chk_out("random", q[k].f, q[k].b, q[k].d, q[k].p, 1'b0);
                if (q[k].b) scramble_cfg();
                else start = 1'b0;
            end
            start = 1'b0;
            last = q[q.size() - 1];
            if (last.b) begin
                do_abort();
                chk_out("random_abort", last.f, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
